// File: rtl/seq_shifter_if.sv
// Request/response bundle for the sequential shifter: operand, mode and amount in,
// status and result out.
interface seq_shifter_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
);
    logic               start;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   din;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   dout;
    logic               cout;

    modport master (
        output start, mode, din, shamt,
        input  busy, done, dout, cout
    );

    modport slave (
        input  start, mode, din, shamt,
        output busy, done, dout, cout
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock (SLL/SRL/SRA/ROL), done pulse on completion.
// dout is the working register itself, so the result holds until the next accepted start.
module seq_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    seq_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         mode_q;
    logic               cout_q;
    logic [WIDTH-1:0]   shifted;
    logic               shout;
    logic               accept;

    // start is only looked at outside SHIFT; reset masks it entirely
    assign accept = bus.start && (state != SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (bus.shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == SHAMT_W'(1)) state_nxt = DONE;
            DONE:    if (accept) state_nxt = (bus.shamt != '0) ? SHIFT : DONE;
                     else        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // single-bit step of the latched operation
    always_comb begin
        shifted = work;
        shout   = 1'b0;
        case (mode_q)
            M_SLL: begin
                shifted = {work[WIDTH-2:0], 1'b0};
                shout   = work[WIDTH-1];
            end
            M_SRL: begin
                shifted = {1'b0, work[WIDTH-1:1]};
                shout   = work[0];
            end
            M_SRA: begin
                shifted = {work[WIDTH-1], work[WIDTH-1:1]};
                shout   = work[0];
            end
            default: begin
                shifted = {work[WIDTH-2:0], work[WIDTH-1]};
                shout   = work[WIDTH-1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work   <= '0;
            cnt    <= '0;
            mode_q <= 2'b00;
            cout_q <= 1'b0;
        end else if (accept) begin
            work   <= bus.din;
            cnt    <= bus.shamt;
            mode_q <= bus.mode;
            cout_q <= 1'b0;
        end else if (state == SHIFT) begin
            work   <= shifted;
            cnt    <= cnt - SHAMT_W'(1);
            cout_q <= shout;
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.dout = work;
    assign bus.cout = cout_q;
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter SHAMT_W, default 4, shift-amount width; ceil(log2(WIDTH)) required.
REQ-003 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port start  input  1  request; sampled only when busy=0.
REQ-007 The block SHALL have port mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL; sampled with start.
REQ-008 The block SHALL have port din  input  WIDTH  operand; sampled with start.
REQ-009 The block SHALL have port shamt  input  SHAMT_W  shift amount; sampled with start.
REQ-010 The block SHALL have port busy  output  1  high while shifting.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 The block SHALL have port dout  output  WIDTH  result register.
REQ-013 The block SHALL have port cout  output  1  last bit shifted or rotated out.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE; busy=1 only in SHIFT; done=1 only in DONE.
REQ-015 In IDLE or DONE, start=1 SHALL load din into the working register, shamt into counter cnt and mode into a mode register, and SHALL clear cout.
REQ-016 On that load, next state SHALL be SHIFT if shamt!=0, else DONE.
REQ-017 In SHIFT, each cycle SHALL shift the working register by exactly one bit per the latched mode and decrement cnt; the cycle with cnt==1 SHALL move to DONE.
REQ-018 SLL SHALL shift left with 0 fill, cout<=old MSB.
REQ-019 SRL SHALL shift right with 0 fill, cout<=old LSB.
REQ-020 SRA SHALL shift right replicating the old MSB, cout<=old LSB.
REQ-021 ROL SHALL rotate left (old MSB to LSB), cout<=old MSB.
REQ-022 Latency: done SHALL assert in the cycle shamt+1 clocks after the start edge; throughput one operation per shamt+1 cycles.
REQ-023 dout SHALL present the working register continuously; it equals the result while done=1 and holds until the next accepted start.
REQ-024 cout SHALL hold its last value until the next accepted start; shamt=0 gives cout=0 and dout=din.
REQ-025 start while busy=1 SHALL be ignored; din, shamt and mode changes during SHIFT SHALL have no effect.
REQ-026 start in DONE SHALL be accepted (back-to-back); done still pulses for that one cycle only.
REQ-027 In DONE without start, next state SHALL be IDLE.
REQ-028 Width rule: no bit beyond WIDTH-1 is stored; for SLL/SRL/SRA, bits shifted out are lost except the last, which is kept in cout.

Reset
REQ-029 reset=1 at a clock edge SHALL force state IDLE, busy=0, done=0, dout=0, cout=0, cnt=0, mode register=00.
REQ-030 reset SHALL take priority over start and over any in-progress SHIFT; the aborted operation produces no done pulse.
REQ-031 With reset and start both high, start SHALL be ignored.

Verification
REQ-032 SLL: din=16'h8001, shamt=1, mode=00 -> done at cycle 2 after start, dout=16'h0002, cout=1.
REQ-033 SRA: din=16'h8000, shamt=15, mode=10 -> busy high 15 cycles, done at cycle 16, dout=16'hFFFF, cout=0; same input with mode=01 -> dout=16'h0001, cout=0.
REQ-034 ROL: din=16'h1234, shamt=4, mode=11 -> dout=16'h2341, cout=1; shamt=0, any mode -> done next cycle, dout=16'h1234, cout=0.
REQ-035 Busy/back-to-back: start SLL 16'h0001 shamt=3; pulse start again with other data at cycle 1 -> ignored, dout=16'h0008; start asserted in the DONE cycle -> accepted, second done after its own shamt+1 cycles.
REQ-036 Reset mid-op: start SRL 16'hFFFF shamt=8; reset at cycle 4 -> next cycle busy=0, dout=0, cout=0, no done pulse; new op afterwards completes normally.
REQ-037 Parameter: WIDTH=8, SHAMT_W=3, din=8'h81, shamt=7, mode=11 -> dout=8'hC0, cout=0, done at cycle 8.
